demux3_5: RTL and testbench

- Three-way 5-bit dispatcher. It is the write-side counterpart of the 3:1 select mux: one upstream source, three downstream sinks.
- Each accepted word is steered by a 2-bit `choose` code to sink A, B or C, and is held in that sink's one-entry output register under a valid/ready handshake.
- Used wherever a shared 5-bit field (sprite index, column id, register address) must be delivered to one of three consumers without losing words when a consumer stalls.

---
 rtl/demux3_5_if.sv | 25 ++
 rtl/demux3_5.sv | 92 +++++++++
 tb/tb_demux3_5.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/demux3_5_if.sv
// Upstream/downstream handshake bundle for the 3-way 5-bit dispatcher.
// The master drives the upstream word and the sink readies; the slave is the dispatcher.
interface demux3_5_if #(
    parameter int WIDTH = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_choose;
    logic [2:0]       out_valid;
    logic [2:0]       out_ready;
    logic [WIDTH-1:0] out_data_a;
    logic [WIDTH-1:0] out_data_b;
    logic [WIDTH-1:0] out_data_c;

    modport master (
        output in_valid, in_data, in_choose, out_ready,
        input  in_ready, out_valid, out_data_a, out_data_b, out_data_c
    );

    modport slave (
        input  in_valid, in_data, in_choose, out_ready,
        output in_ready, out_valid, out_data_a, out_data_b, out_data_c
    );
endinterface

// File: rtl/demux3_5.sv
// Three-way dispatcher: each accepted word is steered by a 2-bit code into one of
// three one-entry output registers; code 11 is accepted, dropped and counted.
module demux3_5_slot #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic             ready,
    output logic             slot_valid,
    output logic [WIDTH-1:0] slot_data
);
    // Free or draining this cycle: a new word can replace the outgoing one.
    assign ready = !slot_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= 1'b0;
            slot_data  <= '0;
        end else if (load) begin
            slot_valid <= 1'b1;
            slot_data  <= in_data;
        end else if (slot_valid && out_ready) begin
            slot_valid <= 1'b0;
        end
    end
endmodule

module demux3_5 #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    demux3_5_if.slave        bus,
    output logic             err,
    output logic [CNT_W-1:0] drop_count
);
    localparam int NSINK = 3;

    logic [NSINK-1:0]            sink_ready;
    logic [NSINK-1:0]            load;
    logic [NSINK-1:0]            slot_valid;
    logic [NSINK-1:0][WIDTH-1:0] slot_data;
    logic                        illegal;

    assign illegal = (bus.in_choose == 2'b11);

    always_comb begin
        bus.in_ready = 1'b1;
        case (bus.in_choose)
            2'b00:   bus.in_ready = sink_ready[0];
            2'b01:   bus.in_ready = sink_ready[1];
            2'b10:   bus.in_ready = sink_ready[2];
            default: bus.in_ready = 1'b1;
        endcase
    end

    for (genvar k = 0; k < NSINK; k++) begin : g_sink
        assign load[k] = bus.in_valid && (bus.in_choose == 2'(k)) && sink_ready[k];

        demux3_5_slot #(.WIDTH(WIDTH)) u_slot (
            .clk        (clk),
            .rst        (rst),
            .load       (load[k]),
            .in_data    (bus.in_data),
            .out_ready  (bus.out_ready[k]),
            .ready      (sink_ready[k]),
            .slot_valid (slot_valid[k]),
            .slot_data  (slot_data[k])
        );
    end

    assign bus.out_valid  = slot_valid;
    assign bus.out_data_a = slot_data[0];
    assign bus.out_data_b = slot_data[1];
    assign bus.out_data_c = slot_data[2];

    // Illegal words are always accepted, so fire reduces to in_valid here.
    always_ff @(posedge clk) begin
        if (rst) begin
            err        <= 1'b0;
            drop_count <= '0;
        end else begin
            err <= bus.in_valid && illegal;
            if (bus.in_valid && illegal && (drop_count != {CNT_W{1'b1}}))
                drop_count <= drop_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_demux3_5.sv
// Directed plus randomized check of demux3_5 against a slot/counter reference model.
module tb_demux3_5;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       err;
    logic [7:0] drop_count;

    int n_assert = 0;
    int n_fail   = 0;

    demux3_5_if #(.WIDTH(5)) bus ();

    demux3_5 #(.WIDTH(5), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .err        (err),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // Reference state: what each sink should be holding, plus error/counter.
    logic       m_valid [3];
    logic [4:0] m_data  [3];
    logic       m_err;
    int         m_cnt;

    function automatic logic m_ready(input logic [1:0] ch, input logic [2:0] r);
        if (ch == 2'b11) return 1'b1;
        return !m_valid[ch] || r[ch];
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 3; k++) begin
            m_valid[k] = 1'b0;
            m_data[k]  = 5'h00;
        end
        m_err = 1'b0;
        m_cnt = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs();
        chk("out_valid",  {29'd0, bus.out_valid}, {29'd0, m_valid[2], m_valid[1], m_valid[0]});
        chk("out_data_a", {27'd0, bus.out_data_a}, {27'd0, m_data[0]});
        chk("out_data_b", {27'd0, bus.out_data_b}, {27'd0, m_data[1]});
        chk("out_data_c", {27'd0, bus.out_data_c}, {27'd0, m_data[2]});
        chk("err",        {31'd0, err}, {31'd0, m_err});
        chk("drop_count", {24'd0, drop_count}, 32'(m_cnt));
    endtask

    // One clock: drive inputs, check combinational ready, clock, advance model, check state.
    task automatic cyc(input logic v, input logic [4:0] d, input logic [1:0] ch, input logic [2:0] r);
        logic fire;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_choose = ch;
        bus.out_ready = r;
        #1;
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, m_ready(ch, r)});
        fire = v && m_ready(ch, r);
        @(posedge clk);
        if (rst) begin
            m_reset();
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (fire && ch == 2'(k)) begin
                    m_valid[k] = 1'b1;
                    m_data[k]  = d;
                end else if (m_valid[k] && r[k]) begin
                    m_valid[k] = 1'b0;
                end
            end
            m_err = fire && (ch == 2'b11);
            if (m_err && m_cnt < 255) m_cnt = m_cnt + 1;
        end
        #1;
        chk_outputs();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 5'h00;
        bus.in_choose = 2'b00;
        bus.out_ready = 3'b000;
        m_reset();

        // Reset held two cycles, then idle with every choose value.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) cyc(1'b0, 5'h00, 2'(c), 3'b000);

        // Single word to B, then drained.
        cyc(1'b1, 5'h13, 2'b01, 3'b000);
        chk("single_b", {27'd0, bus.out_data_b}, 32'h13);
        cyc(1'b0, 5'h00, 2'b00, 3'b010);
        chk("single_drained", {29'd0, bus.out_valid}, 32'h0);

        // Stall on A, then pass-through on drain.
        cyc(1'b1, 5'h01, 2'b00, 3'b000);
        cyc(1'b1, 5'h02, 2'b00, 3'b000);
        chk("stall_hold_a", {27'd0, bus.out_data_a}, 32'h01);
        cyc(1'b1, 5'h02, 2'b00, 3'b001);
        chk("passthru_a", {27'd0, bus.out_data_a}, 32'h02);
        cyc(1'b0, 5'h00, 2'b00, 3'b001);

        // A stalled with 07 while B and C flow.
        cyc(1'b1, 5'h07, 2'b00, 3'b000);
        cyc(1'b1, 5'h0A, 2'b01, 3'b000);
        cyc(1'b1, 5'h0C, 2'b10, 3'b000);
        chk("indep_b", {27'd0, bus.out_data_b}, 32'h0A);
        chk("indep_c", {27'd0, bus.out_data_c}, 32'h0C);
        chk("indep_a", {27'd0, bus.out_data_a}, 32'h07);
        cyc(1'b0, 5'h00, 2'b00, 3'b110);
        cyc(1'b0, 5'h00, 2'b00, 3'b001);

        // Illegal codes: three back-to-back, then saturation.
        for (int i = 0; i < 3; i++) cyc(1'b1, 5'($urandom), 2'b11, 3'b000);
        chk("drop3", {24'd0, drop_count}, 32'd3);
        cyc(1'b0, 5'h00, 2'b11, 3'b000);
        for (int i = 0; i < 256; i++) cyc(1'b1, 5'($urandom), 2'b11, 3'($urandom));
        chk("drop_sat", {24'd0, drop_count}, 32'd255);
        cyc(1'b1, 5'h00, 2'b11, 3'b000);

        // Reset while C is stalled; reset wins over a same-cycle transfer.
        cyc(1'b1, 5'h1F, 2'b10, 3'b000);
        rst = 1'b1;
        cyc(1'b1, 5'h05, 2'b10, 3'b000);
        rst = 1'b0;
        chk("rst_c_data", {27'd0, bus.out_data_c}, 32'h0);
        chk("rst_valid", {29'd0, bus.out_valid}, 32'h0);

        // Random traffic.
        for (int i = 0; i < 600; i++)
            cyc(1'($urandom), 5'($urandom), 2'($urandom), 3'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
